dm_lsu: RTL
===========

DM_LSU -- requirements
Module: dm_lsu

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 req  input  1  access request; sampled only in IDLE.
REQ-004 wr  input  1  1 = store, 0 = load.
REQ-005 size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-006 uns  input  1  load zero-extend when 1, sign-extend when 0; ignored for stores and word loads.
REQ-007 addr  input  10  byte address.
REQ-008 wdata  input  32  store data; byte/halfword stores use wdata[7:0] / wdata[15:0].
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  valid with done; 1 = misaligned or illegal size.
REQ-012 rdata  output  32  load result; updated only at load completion, held otherwise.
REQ-013 dm_addr  output  10  byte address to data memory; always word-aligned.
REQ-014 dm_we  output  1  data memory write enable; memory writes 4 bytes at dm_addr..dm_addr+3 on rising edge.
REQ-015 dm_din  output  32  write word; bits[7:0] go to byte dm_addr (little-endian).
REQ-016 dm_dout  input  32  combinational read word from memory at dm_addr; bits[7:0] = byte dm_addr.

Function
REQ-017 States IDLE, ACCESS, WRITE, DONE; busy = (state != IDLE).
REQ-018 IDLE: on req=1, latch wr/size/uns/addr/wdata; legal and aligned -> ACCESS; otherwise -> DONE with err flag set, no memory cycle.
REQ-019 Alignment: word requires addr[1:0]=00, halfword requires addr[0]=0, byte always aligned; size=11 is always an error.
REQ-020 Outside IDLE, dm_addr = {latched addr[9:2], 2'b00}; in IDLE, dm_addr = 0.
REQ-021 ACCESS, load: capture dm_dout in the same cycle, extract the field at offset addr[1:0] (byte k = bits[8k+7:8k]; halfword at offset 0 = [15:0], offset 2 = [31:16]), extend per uns, write to rdata, -> DONE.
REQ-022 ACCESS, word store: dm_we=1, dm_din=wdata, -> DONE.
REQ-023 ACCESS, byte/halfword store: capture dm_dout into merge register with the addressed lane replaced by wdata low bits, -> WRITE.
REQ-024 WRITE: dm_we=1, dm_din=merge register, -> DONE; bytes outside the addressed lane are written back unchanged.
REQ-025 DONE: done=1 and err=latched error flag for exactly one cycle, -> IDLE; req sampled in DONE is ignored.
REQ-026 Latency from the request edge to the done cycle: load/word store 2 cycles; byte/halfword store 3 cycles; error 1 cycle.
REQ-027 req while busy is ignored and not queued; input changes after the request edge have no effect.
REQ-028 dm_we=0 and dm_din=0 in all states other than those specified in REQ-022 and REQ-024.
REQ-029 On an error completion, rdata keeps its previous value and no memory write occurs.

Reset
REQ-030 rst=1 at an edge: state -> IDLE, busy=0, done=0, err=0, rdata=0, merge/latch registers=0.
REQ-031 dm_we is gated by ~rst: no memory write occurs in any cycle with rst=1, including mid-operation in ACCESS or WRITE.
REQ-032 When reset aborts an operation, no done pulse is issued for that operation.

Verification
REQ-033 Memory word@0x10 = 0x8899AABB; lb at addr 0x13 -> done at +2 cycles, rdata=0xFFFFFF88, err=0; lbu at addr 0x13 -> rdata=0x00000088.
REQ-034 Memory word@0x10 = 0x8899AABB; lh at addr 0x12 -> rdata=0xFFFF8899; lhu at addr 0x10 -> rdata=0x0000AABB.
REQ-035 sb wdata=0x123456CC at addr 0x21 over word@0x20 = 0x11223344 -> dm_we high only in the WRITE cycle, dm_din=0x1122CC44, done at +3 cycles; a following lw at 0x20 returns 0x1122CC44.
REQ-036 sw at addr 0x06, lh at addr 0x03, and size=11 each give done at +1 cycle with err=1, dm_we never high, and rdata unchanged.
REQ-037 sh at addr 0x40 with rst asserted in the WRITE cycle -> dm_we=0 in that cycle, memory unchanged, no done pulse, busy=0 after the edge.
REQ-038 req pulses during busy of an lw -> exactly one done pulse, and the next request is accepted only in IDLE.

Source files
------------

// File: rtl/dm_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_lsu_if
// Purpose  : Request/response and data-memory signals of the load/store unit
// Revision : 1.0
// ============================================================================
interface dm_lsu_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [9:0]  dm_addr;
    logic        dm_we;
    logic [31:0] dm_din;
    logic [31:0] dm_dout;

    // master: requester plus the memory that answers dm_dout; slave: the LSU itself
    modport master (
        output req, wr, size, uns, addr, wdata, dm_dout,
        input  busy, done, err, rdata, dm_addr, dm_we, dm_din
    );

    modport slave (
        input  req, wr, size, uns, addr, wdata, dm_dout,
        output busy, done, err, rdata, dm_addr, dm_we, dm_din
    );
endinterface
`default_nettype wire

// File: rtl/dm_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dm_lsu
// Purpose  : Byte/halfword/word load-store unit; sub-word stores use read-modify-write
// Revision : 1.0
// ============================================================================
module dm_lsu (
    input  logic    clk,
    input  logic    rst,
    dm_lsu_if.slave bus
);
    localparam logic [1:0] C_IDLE    = 2'd0;
    localparam logic [1:0] C_ACCESS  = 2'd1;
    localparam logic [1:0] C_WRITE   = 2'd2;
    localparam logic [1:0] C_DONE    = 2'd3;

    localparam logic [1:0] C_SZ_BYTE = 2'b00;
    localparam logic [1:0] C_SZ_HALF = 2'b01;
    localparam logic [1:0] C_SZ_WORD = 2'b10;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic        r_wr;
    logic        r_uns;
    logic        r_err;
    logic [1:0]  r_size;
    logic [9:0]  r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;

    logic        w_req_bad;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [4:0]  w_shamt;
    logic [31:0] w_lane_mask;
    logic [31:0] w_lane_data;
    logic [31:0] w_merge;

    always_comb begin
        case (bus.size)
            C_SZ_WORD: w_req_bad = (bus.addr[1:0] != 2'b00);
            C_SZ_HALF: w_req_bad = bus.addr[0];
            C_SZ_BYTE: w_req_bad = 1'b0;
            default:   w_req_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            C_IDLE: begin
                if (bus.req) begin
                    w_next = w_req_bad ? C_DONE : C_ACCESS;
                end
            end
            C_ACCESS: w_next = (r_wr && (r_size != C_SZ_WORD)) ? C_WRITE : C_DONE;
            C_WRITE:  w_next = C_DONE;
            default:  w_next = C_IDLE;
        endcase
    end

    // Load field extraction and sub-word store lane merge, both off the live read word
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = bus.dm_dout[7:0];
            2'd1:    w_byte = bus.dm_dout[15:8];
            2'd2:    w_byte = bus.dm_dout[23:16];
            default: w_byte = bus.dm_dout[31:24];
        endcase
        w_half = r_addr[1] ? bus.dm_dout[31:16] : bus.dm_dout[15:0];
        case (r_size)
            C_SZ_BYTE: w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
            C_SZ_HALF: w_load = {{16{~r_uns & w_half[15]}}, w_half};
            default:   w_load = bus.dm_dout;
        endcase
        w_shamt     = {r_addr[1:0], 3'b000};
        w_lane_mask = ((r_size == C_SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shamt;
        w_lane_data = ((r_size == C_SZ_BYTE) ? {24'd0, r_wdata[7:0]}
                                             : {16'd0, r_wdata[15:0]}) << w_shamt;
        w_merge     = (bus.dm_dout & ~w_lane_mask) | (w_lane_data & w_lane_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= 1'b0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= 10'd0;
            r_wdata <= 32'd0;
            r_merge <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            if ((r_state == C_IDLE) && bus.req) begin
                r_wr    <= bus.wr;
                r_uns   <= bus.uns;
                r_size  <= bus.size;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
                r_err   <= w_req_bad;
            end
            if (r_state == C_ACCESS) begin
                if (r_wr) begin
                    r_merge <= w_merge;
                end else begin
                    r_rdata <= w_load;
                end
            end
        end
    end

    // Write enable is masked by rst so an aborted operation never touches memory
    always_comb begin
        bus.busy    = (r_state != C_IDLE);
        bus.done    = (r_state == C_DONE);
        bus.err     = (r_state == C_DONE) & r_err;
        bus.dm_addr = 10'd0;
        bus.dm_we   = 1'b0;
        bus.dm_din  = 32'd0;
        if (r_state != C_IDLE) begin
            bus.dm_addr = {r_addr[9:2], 2'b00};
        end
        case (r_state)
            C_ACCESS: begin
                if (r_wr && (r_size == C_SZ_WORD)) begin
                    bus.dm_we  = ~rst;
                    bus.dm_din = r_wdata;
                end
            end
            C_WRITE: begin
                bus.dm_we  = ~rst;
                bus.dm_din = r_merge;
            end
            default: ;
        endcase
    end

    assign bus.rdata = r_rdata;
endmodule
`default_nettype wire
